// File: rtl/exhaustive_stim_capture.sv
// Exhaustive stimulus sequencer and response-capture stage.
// Sweeps every N_IN-bit pattern in ascending order into a single-output DUT.
// Each pattern's response is captured after a programmable settle time into a
// truth-table bitmap, a ones counter and a MISR signature.
module exhaustive_stim_capture #(
  parameter int unsigned        N_IN      = 5,
  parameter int unsigned        SETTLE    = 1,
  parameter int unsigned        MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = 16'h1021
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  output logic [N_IN-1:0]   pattern_out,
  input  logic              dut_resp,
  output logic              busy,
  output logic              done,
  input  logic [N_IN-1:0]   rd_addr,
  output logic              rd_data,
  output logic [N_IN:0]     ones_count,
  output logic [MISR_W-1:0] signature
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ONES_W = N_IN + 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  settle_cnt_d;
  logic [N_IN-1:0]   pattern_d;
  logic [ONES_W-1:0] ones_d;
  logic [MISR_W-1:0] sig_d;
  logic              busy_d;
  logic              done_d;
  logic [DEPTH-1:0]  bitmap;

  logic              sample_c;
  logic              last_c;
  logic [MISR_W-1:0] misr_next_c;

  // Sample edge: settle time for the current pattern has elapsed.
  always_comb begin
    sample_c    = (state == ST_WAIT) && (settle_cnt == '0);
    last_c      = (pattern_out == {N_IN{1'b1}});
    misr_next_c = {signature[MISR_W-2:0], 1'b0}
                ^ (signature[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                ^ MISR_W'(dut_resp);
  end

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    pattern_d    = pattern_out;
    ones_d       = ones_count;
    sig_d        = signature;
    busy_d       = busy;
    done_d       = done;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_WAIT;
          pattern_d    = '0;
          settle_cnt_d = SETTLE_INIT;
          ones_d       = '0;
          sig_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
        end
      end
      ST_WAIT: begin
        if (settle_cnt != '0) begin
          settle_cnt_d = settle_cnt - 1'b1;
        end else begin
          ones_d = ones_count + ONES_W'(dut_resp);
          sig_d  = misr_next_c;
          if (last_c) begin
            // Final pattern: hold all-ones rather than wrapping.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pattern_d    = pattern_out + 1'b1;
            settle_cnt_d = SETTLE_INIT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and result registers.
  always_ff @(posedge CK) begin
    if (reset) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      pattern_out <= '0;
      ones_count  <= '0;
      signature   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      settle_cnt  <= settle_cnt_d;
      pattern_out <= pattern_d;
      ones_count  <= ones_d;
      signature   <= sig_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Truth-table bitmap; no clear on start since a sweep rewrites every entry.
  always_ff @(posedge CK) begin
    if (reset) begin
      bitmap <= '0;
    end else if (sample_c) begin
      bitmap[pattern_out] <= dut_resp;
    end
  end

  // Registered read port; a same-edge write is seen on the following read.
  always_ff @(posedge CK) begin
    if (reset) begin
      rd_data <= 1'b0;
    end else begin
      rd_data <= bitmap[rd_addr];
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// Self-checking bench: three sequencer instances (SETTLE=0,1,2) driving a
// behavioural DUT whose response function is selectable per instance.
module tb_exhaustive_stim_capture;

  localparam int M_ZERO  = 0;
  localparam int M_ONE   = 1;
  localparam int M_MATCH = 2;
  localparam int M_PAR   = 3;
  localparam int M_RAND  = 4;

  logic        CK = 1'b0;
  logic        reset = 1'b1;
  logic        start_v   [3];
  logic [4:0]  pat_v     [3];
  logic        resp_v    [3];
  logic        busy_v    [3];
  logic        done_v    [3];
  logic [4:0]  rd_addr_v [3];
  logic        rd_data_v [3];
  logic [5:0]  ones_v    [3];
  logic [15:0] sig_v     [3];
  int          mode_v    [3];
  logic [31:0] rand_tt   [3];

  int total = 0;
  int bad   = 0;

  always #5 CK = ~CK;

  // Behavioural DUT: single output as a function of its 5-bit input.
  function automatic logic resp_of(input int mode, input logic [31:0] tt, input logic [4:0] p);
    case (mode)
      M_ONE:   resp_of = 1'b1;
      M_MATCH: resp_of = (p == 5'd22);
      M_PAR:   resp_of = ^p;
      M_RAND:  resp_of = tt[p];
      default: resp_of = 1'b0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign resp_v[g] = resp_of(mode_v[g], rand_tt[g], pat_v[g]);
    exhaustive_stim_capture #(
      .N_IN(5), .SETTLE(g), .MISR_W(16), .MISR_POLY(16'h1021)
    ) u_dut (
      .CK(CK), .reset(reset), .start(start_v[g]), .pattern_out(pat_v[g]),
      .dut_resp(resp_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .rd_addr(rd_addr_v[g]), .rd_data(rd_data_v[g]),
      .ones_count(ones_v[g]), .signature(sig_v[g])
    );
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (pat_v[k] !== 5'd0) begin bad++; $display("FAIL reset_pat[%0d] got=%0d want=0", k, pat_v[k]); end
      total++; if (busy_v[k] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", k, busy_v[k]); end
      total++; if (done_v[k] !== 1'b0) begin bad++; $display("FAIL reset_done[%0d] got=%b want=0", k, done_v[k]); end
      total++; if (rd_data_v[k] !== 1'b0) begin bad++; $display("FAIL reset_rd[%0d] got=%b want=0", k, rd_data_v[k]); end
      total++; if (ones_v[k] !== 6'd0) begin bad++; $display("FAIL reset_ones[%0d] got=%0d want=0", k, ones_v[k]); end
      total++; if (sig_v[k] !== 16'h0) begin bad++; $display("FAIL reset_sig[%0d] got=%h want=0000", k, sig_v[k]); end
    end
    @(negedge CK);
    reset = 1'b0;
  endtask

  // Full sweep on instance k with response mode; checks timing, hold, results.
  task automatic test_sweep(input int k, input int mode, input string name);
    int          s = k;
    int          n;
    int          hold_err;
    int          busy_err;
    bit          got_done;
    logic [31:0] exp_tt;
    int          exp_ones;
    logic [15:0] exp_sig;
    logic        r;

    exp_tt = '0; exp_ones = 0; exp_sig = '0;
    for (int p = 0; p < 32; p++) begin
      r = resp_of(mode, rand_tt[k], 5'(p));
      exp_tt[p] = r;
      exp_ones += int'(r);
      exp_sig = {exp_sig[14:0], 1'b0} ^ (exp_sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
    end

    mode_v[k] = mode;
    @(negedge CK);
    start_v[k] = 1'b1;
    @(posedge CK);
    #1;
    start_v[k] = 1'b0;
    total++; if (busy_v[k] !== 1'b1) begin bad++; $display("FAIL %s_busy_start got=%b want=1", name, busy_v[k]); end
    total++; if (done_v[k] !== 1'b0) begin bad++; $display("FAIL %s_done_start got=%b want=0", name, done_v[k]); end
    total++; if (ones_v[k] !== 6'd0) begin bad++; $display("FAIL %s_ones_start got=%0d want=0", name, ones_v[k]); end
    total++; if (sig_v[k] !== 16'h0) begin bad++; $display("FAIL %s_sig_start got=%h want=0000", name, sig_v[k]); end

    n = 0; hold_err = 0; busy_err = 0; got_done = 1'b0;
    while (n < 1000) begin
      if (pat_v[k] !== 5'(n / (s + 1))) hold_err++;
      if (busy_v[k] !== 1'b1) busy_err++;
      @(posedge CK);
      #1;
      n++;
      if (done_v[k] === 1'b1) begin got_done = 1'b1; break; end
    end
    total++; if (!got_done || n != 32 * (s + 1)) begin bad++; $display("FAIL %s_done_edge got=%0d want=%0d", name, got_done ? n : -1, 32 * (s + 1)); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL %s_hold errors=%0d want=0", name, hold_err); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL %s_busy_during errors=%0d want=0", name, busy_err); end
    total++; if (busy_v[k] !== 1'b0) begin bad++; $display("FAIL %s_busy_end got=%b want=0", name, busy_v[k]); end
    total++; if (pat_v[k] !== 5'd31) begin bad++; $display("FAIL %s_pat_end got=%0d want=31", name, pat_v[k]); end
    total++; if (ones_v[k] !== 6'(exp_ones)) begin bad++; $display("FAIL %s_ones got=%0d want=%0d", name, ones_v[k], exp_ones); end
    total++; if (sig_v[k] !== exp_sig) begin bad++; $display("FAIL %s_sig got=%h want=%h", name, sig_v[k], exp_sig); end

    for (int a = 0; a < 32; a++) begin
      @(negedge CK);
      rd_addr_v[k] = 5'(a);
      @(posedge CK);
      #1;
      total++; if (rd_data_v[k] !== exp_tt[a]) begin bad++; $display("FAIL %s_rd[%0d] got=%b want=%b", name, a, rd_data_v[k], exp_tt[a]); end
    end
    total++; if (done_v[k] !== 1'b1 || pat_v[k] !== 5'd31) begin bad++; $display("FAIL %s_done_hold got=%b/%0d want=1/31", name, done_v[k], pat_v[k]); end
  endtask

  task automatic test_zero;
    test_sweep(1, M_ZERO, "zero");
  endtask

  task automatic test_single;
    test_sweep(0, M_MATCH, "single");
  endtask

  task automatic test_parity;
    test_sweep(2, M_PAR, "parity");
  endtask

  task automatic test_random;
    for (int k = 0; k < 3; k++) begin
      rand_tt[k] = $urandom;
      test_sweep(k, M_RAND, "rand");
    end
  endtask

  // Extra start mid-sweep is ignored; reset at pattern 7 clears everything.
  task automatic test_start_then_reset;
    int n = 0;
    int hold_err = 0;
    bit hit = 1'b0;
    mode_v[1] = M_ONE;
    @(negedge CK);
    start_v[1] = 1'b1;
    @(posedge CK);
    #1;
    start_v[1] = 1'b0;
    while (n < 200) begin
      if (pat_v[1] !== 5'(n / 2)) hold_err++;
      if (pat_v[1] === 5'd7) begin hit = 1'b1; break; end
      start_v[1] = (n == 4);
      @(posedge CK);
      #1;
      n++;
    end
    start_v[1] = 1'b0;
    total++; if (!hit || hold_err != 0) begin bad++; $display("FAIL busy_start_hold reached=%b errors=%0d want=1/0", hit, hold_err); end
    total++; if (ones_v[1] !== 6'd7) begin bad++; $display("FAIL pre_reset_ones got=%0d want=7", ones_v[1]); end

    reset = 1'b1;
    start_v[1] = 1'b1;
    @(posedge CK);
    #1;
    reset = 1'b0;
    start_v[1] = 1'b0;
    total++; if (pat_v[1] !== 5'd0) begin bad++; $display("FAIL mid_reset_pat got=%0d want=0", pat_v[1]); end
    total++; if (busy_v[1] !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy_v[1]); end
    total++; if (done_v[1] !== 1'b0) begin bad++; $display("FAIL mid_reset_done got=%b want=0", done_v[1]); end
    total++; if (ones_v[1] !== 6'd0) begin bad++; $display("FAIL mid_reset_ones got=%0d want=0", ones_v[1]); end
    total++; if (sig_v[1] !== 16'h0) begin bad++; $display("FAIL mid_reset_sig got=%h want=0000", sig_v[1]); end
    @(posedge CK);
    #1;
    total++; if (busy_v[1] !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got=%b want=0", busy_v[1]); end
    for (int a = 0; a < 32; a++) begin
      @(negedge CK);
      rd_addr_v[1] = 5'(a);
      @(posedge CK);
      #1;
      total++; if (rd_data_v[1] !== 1'b0) begin bad++; $display("FAIL mid_reset_rd[%0d] got=%b want=0", a, rd_data_v[1]); end
    end
  endtask

  // Completed all-ones sweep followed by a restart from DONE with zeros.
  task automatic test_back_to_back;
    test_sweep(0, M_ONE, "b2b_ones");
    test_sweep(0, M_ZERO, "b2b_zero");
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      rd_addr_v[k] = '0;
      mode_v[k] = M_ZERO;
      rand_tt[k] = '0;
    end
    test_reset;
    test_zero;
    test_single;
    test_parity;
    test_random;
    test_start_then_reset;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
